// File: rtl/zrb_uart_tx_arbiter_pkg.sv
// zrb_uart_tx_arbiter shared types and constants.
// ZRB_UART_ARB_TAG_EN adds a header-byte state.
package zrb_uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_TAG   = 2'd3
  } arb_state_e;

  localparam int MAX_LEN_DEF = 64;

  // grant id sits in the low bits of the tag byte
  localparam int TAG_ID_LSB = 0;

endpackage

// File: rtl/zrb_uart_tx_arbiter_if.sv
// Requester bundle and UART tx FIFO write side.
// Master drives bytes and tx_en; slave is the arbiter.
interface zrb_uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          uart_tx_en;
  logic                          uart_wr;
  logic [DATA_WIDTH-1:0]         uart_data;

  modport master (
    output req_valid, req_data, req_last,
    output uart_tx_en,
    input  req_ready, uart_wr, uart_data
  );

  modport slave (
    input  req_valid, req_data, req_last,
    input  uart_tx_en,
    output req_ready, uart_wr, uart_data
  );
endinterface

// File: rtl/zrb_uart_tx_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit
// searching upward from last+1, wrapping.
module zrb_rr_pick
  import zrb_uart_tx_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            found,
  output logic [ID_W-1:0] idx
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0] j;

  // walk from the farthest slot back so the nearest hit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N; k >= 1; k--) begin
      j = SW'((int'(last) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/zrb_uart_tx_arbiter.sv
// Packet-level round-robin arbiter onto UART tx FIFO.
// ZRB_UART_ARB_TAG_EN: prefix each packet with id byte.
module zrb_uart_tx_arbiter
  import zrb_uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int ID_W       = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  zrb_uart_tx_arbiter_if.slave bus,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            err_overlen
);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  localparam logic [ID_W-1:0] LAST_RST =
    ID_W'(NUM_REQ - 1);

`ifdef ZRB_UART_ARB_TAG_EN
  localparam arb_state_e GRANT_ST = ST_TAG;
`else
  localparam arb_state_e GRANT_ST = ST_BUSY;
`endif

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;

  zrb_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (bus.req_valid),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_valid = bus.req_valid[gid_q];
  assign own_last  = bus.req_last[gid_q];
  assign own_data  =
    bus.req_data[int'(gid_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef ZRB_UART_ARB_TAG_EN
  logic [DATA_WIDTH-1:0] tag_byte;
  always_comb begin
    tag_byte = '0;
    tag_byte[TAG_ID_LSB +: ID_W] = gid_q;
  end
`endif

  always_comb begin
    state_d       = state_q;
    gid_d         = gid_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    err_d         = 1'b0;
    bus.req_ready = '0;
    bus.uart_wr   = 1'b0;
    bus.uart_data = own_data;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gid_d   = pick_idx;
          cnt_d   = '0;
          state_d = GRANT_ST;
        end
      end
      ST_BUSY: begin
        bus.req_ready[gid_q] = bus.uart_tx_en;
        bus.uart_wr = own_valid & bus.uart_tx_en;
        if (own_valid & bus.uart_tx_en) begin
          cnt_d = cnt_q + 8'd1;
          if (own_last) begin
            last_d  = gid_q;
            state_d = ST_IDLE;
          end else if (cnt_d == MAX_B) begin
            state_d = ST_DRAIN;
            err_d   = 1'b1;
          end
        end
      end
      // swallow the tail so it is not seen as a new packet
      ST_DRAIN: begin
        bus.req_ready[gid_q] = 1'b1;
        if (own_valid & own_last) begin
          last_d  = gid_q;
          state_d = ST_IDLE;
        end
      end
      ST_TAG: begin
`ifdef ZRB_UART_ARB_TAG_EN
        bus.uart_wr   = bus.uart_tx_en;
        bus.uart_data = tag_byte;
        if (bus.uart_tx_en) state_d = ST_BUSY;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gid_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant_valid = (state_q == ST_BUSY) |
                       (state_q == ST_DRAIN);
  assign grant_id    = gid_q;
  assign err_overlen = err_q;
endmodule

// File: tb/tb_zrb_uart_tx_arbiter.sv
// Self-checking bench for zrb_uart_tx_arbiter.
// Builds with or without ZRB_UART_ARB_TAG_EN.
module tb_zrb_uart_tx_arbiter;
  localparam int NR   = 4;
  localparam int MAXL = 4;
`ifdef ZRB_UART_ARB_TAG_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic       gv;
  logic [1:0] gid;
  logic       err;

  zrb_uart_tx_arbiter_if #(
    .NUM_REQ(NR), .DATA_WIDTH(8)
  ) bus ();

  zrb_uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(8),
    .MAX_LEN(MAXL), .ID_W(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .grant_valid (gv),
    .grant_id    (gid),
    .err_overlen (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // requester byte queues: {last, data}
  logic [8:0]    pq[NR][$];
  logic [NR-1:0] en;
  logic          tx_en;
  int            cyc;

  logic [7:0]    wire_q[$];
  int            wr_cyc[$];
  int            err_cyc[$];
  logic          gv_log[$];

  int            mlen[NR][$];
  logic [7:0]    mb[NR][$];
  logic [7:0]    exp_q[$];

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (en[i] && pq[i].size() > 0) begin
        bus.req_valid[i]     = 1'b1;
        bus.req_data[i*8+:8] = pq[i][0][7:0];
        bus.req_last[i]      = pq[i][0][8];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
      end
    end
    bus.uart_tx_en = tx_en;
    #1;
    cyc++;
    gv_log.push_back(gv);
    if (bus.uart_wr) begin
      wire_q.push_back(bus.uart_data);
      wr_cyc.push_back(cyc);
    end
    if (err) err_cyc.push_back(cyc);
    for (int i = 0; i < NR; i++)
      if (bus.req_valid[i] && bus.req_ready[i])
        void'(pq[i].pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n        = 1'b0;
    en             = '0;
    tx_en          = 1'b1;
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_data   = '0;
    bus.uart_tx_en = 1'b1;
    for (int i = 0; i < NR; i++) pq[i].delete();
    wire_q.delete();
    wr_cyc.delete();
    err_cyc.delete();
    gv_log.delete();
    exp_q.delete();
    cyc = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++)
      if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input int budget,
                                input string nm);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      cycle();
      if (all_empty() && !gv) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s timeout: got busy after %0d cycles, want idle",
               nm, budget);
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.req_valid  = '1;
    bus.req_last   = '1;
    bus.req_data   = 32'hDEADBEEF;
    bus.uart_tx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (gv !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_gv: got %b want 0", gv);
    end
    n_checks++;
    if (gid !== 2'd0) begin
      n_errors++;
      $display("FAIL rst_gid: got %0d want 0", gid);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_err: got %b want 0", err);
    end
    n_checks++;
    if (bus.uart_wr !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_wr: got %b want 0", bus.uart_wr);
    end
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_errors++;
      $display("FAIL rst_ready: got %b want 0000",
               bus.req_ready);
    end
    // abort a packet in flight
    do_reset();
    pq[0] = '{9'h011, 9'h012, 9'h013, 9'h114};
    en = 4'b0001;
    repeat (2 + T) cycle();
    n_checks++;
    if (wire_q.size() != 1 + T) begin
      n_errors++;
      $display("FAIL abort_pre: got %0d writes want %0d",
               wire_q.size(), 1 + T);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.uart_wr !== 1'b0 || gv !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_wr: got wr=%b gv=%b want 0 0",
               bus.uart_wr, gv);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.uart_wr !== 1'b0 || bus.req_ready !== 4'b0) begin
      n_errors++;
      $display("FAIL abort_hold: got wr=%b rdy=%b want 0",
               bus.uart_wr, bus.req_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    pq[0] = '{9'h041, 9'h142};
    en = 4'b0001;
    if (T != 0) exp_q.push_back(8'h00);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    repeat (6 + T) cycle();
    n_checks++;
    if (wire_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL basic_len: got %0d want %0d",
               wire_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_checks++;
        if (wire_q[j] !== exp_q[j]) begin
          n_errors++;
          $display("FAIL basic_byte%0d: got %h want %h",
                   j, wire_q[j], exp_q[j]);
        end
      end
      n_checks++;
      if (wr_cyc[T] != 2 + T || wr_cyc[T+1] != 3 + T) begin
        n_errors++;
        $display("FAIL basic_cyc: got %0d,%0d want %0d,%0d",
                 wr_cyc[T], wr_cyc[T+1], 2 + T, 3 + T);
      end
    end
    n_checks++;
    if (gv_log[1+T] !== 1'b1 || gv_log[3+T] !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_gv: got %b,%b want 1,0",
               gv_log[1+T], gv_log[3+T]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NR; i++) begin
      pq[i].push_back({1'b1, 8'(8'hA0 + i)});
      pq[i].push_back({1'b1, 8'(8'hA0 + i)});
    end
    en = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (T != 0) exp_q.push_back(8'(k % NR));
      exp_q.push_back(8'(8'hA0 + k % NR));
    end
    repeat (5 * (2 + T)) cycle();
    n_checks++;
    if (wire_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL rr_len: got %0d want %0d",
               wire_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_checks++;
        if (wire_q[j] !== exp_q[j]) begin
          n_errors++;
          $display("FAIL rr_byte%0d: got %h want %h",
                   j, wire_q[j], exp_q[j]);
        end
      end
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (wr_cyc[k*(1+T)+T] != (k + 1) * (2 + T)) begin
          n_errors++;
          $display("FAIL rr_space%0d: got cyc %0d want %0d",
                   k, wr_cyc[k*(1+T)+T], (k + 1) * (2 + T));
        end
      end
    end
  endtask

  task automatic test_no_interleave();
    do_reset();
    pq[2] = '{9'h020, 9'h021, 9'h122};
    en = 4'b0100;
    repeat (2 + T) cycle();
    pq[1] = '{9'h010, 9'h111};
    en = 4'b0110;
    run_until_done(40, "intl");
    if (T != 0) exp_q.push_back(8'h02);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h22);
    if (T != 0) exp_q.push_back(8'h01);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    n_checks++;
    if (wire_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL intl_len: got %0d want %0d",
               wire_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_checks++;
        if (wire_q[j] !== exp_q[j]) begin
          n_errors++;
          $display("FAIL intl_byte%0d: got %h want %h",
                   j, wire_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    pq[0] = '{9'h030, 9'h031, 9'h132};
    en = 4'b0001;
    repeat (2 + T) cycle();
    tx_en = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      n_checks++;
      if (bus.uart_wr !== 1'b0 || bus.req_ready !== 4'b0) begin
        n_errors++;
        $display("FAIL stall%0d: got wr=%b rdy=%b want 0",
                 s, bus.uart_wr, bus.req_ready);
      end
    end
    tx_en = 1'b1;
    run_until_done(20, "stall");
    if (T != 0) exp_q.push_back(8'h00);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    n_checks++;
    if (wire_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL stall_len: got %0d want %0d",
               wire_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_checks++;
        if (wire_q[j] !== exp_q[j]) begin
          n_errors++;
          $display("FAIL stall_byte%0d: got %h want %h",
                   j, wire_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_overlen();
    do_reset();
    for (int b = 0; b < 6; b++)
      pq[1].push_back({b == 5, 8'(8'h50 + b)});
    en = 4'b0010;
    run_until_done(30, "ovl");
    if (T != 0) exp_q.push_back(8'h01);
    for (int b = 0; b < MAXL; b++)
      exp_q.push_back(8'(8'h50 + b));
    n_checks++;
    if (wire_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL ovl_len: got %0d want %0d",
               wire_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_checks++;
        if (wire_q[j] !== exp_q[j]) begin
          n_errors++;
          $display("FAIL ovl_byte%0d: got %h want %h",
                   j, wire_q[j], exp_q[j]);
        end
      end
    end
    n_checks++;
    if (err_cyc.size() != 1) begin
      n_errors++;
      $display("FAIL ovl_errcnt: got %0d pulses want 1",
               err_cyc.size());
    end else if (wr_cyc.size() > 0) begin
      n_checks++;
      if (err_cyc[0] != wr_cyc[wr_cyc.size()-1] + 1) begin
        n_errors++;
        $display("FAIL ovl_errcyc: got %0d want %0d",
                 err_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_random();
    int rr;
    int left;
    int exp_err;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      mlen[i].delete();
      mb[i].delete();
    end
    for (int p = 0; p < 40; p++) begin
      int r;
      int len;
      r   = $urandom_range(0, NR - 1);
      len = $urandom_range(1, 7);
      mlen[r].push_back(len);
      for (int b = 0; b < len; b++) begin
        logic [7:0] d;
        d = 8'($urandom);
        pq[r].push_back({b == len - 1, d});
        mb[r].push_back(d);
      end
    end
    // packet-level reference: every queued requester is
    // always offering, so order is pure rotation
    rr      = NR - 1;
    left    = 40;
    exp_err = 0;
    while (left > 0) begin
      int pick;
      int len;
      pick = -1;
      for (int k = 1; k <= NR; k++)
        if (pick < 0 && mlen[(rr + k) % NR].size() > 0)
          pick = (rr + k) % NR;
      len = mlen[pick].pop_front();
      if (T != 0) exp_q.push_back(8'(pick));
      for (int b = 0; b < len; b++) begin
        logic [7:0] d;
        d = mb[pick].pop_front();
        if (b < MAXL) exp_q.push_back(d);
      end
      if (len > MAXL) exp_err++;
      rr = pick;
      left--;
    end
    en = 4'b1111;
    begin
      bit done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
        tx_en = ($urandom_range(0, 3) != 0);
        cycle();
        n_checks++;
        if ((bus.uart_wr && !tx_en) ||
            $countones(bus.req_ready) > 1) begin
          n_errors++;
          $display("FAIL rnd_inv cyc %0d: got wr=%b rdy=%b tx=%b",
                   cyc, bus.uart_wr, bus.req_ready, tx_en);
        end
        if (all_empty() && !gv) done = 1'b1;
      end
      n_checks++;
      if (!done) begin
        n_errors++;
        $display("FAIL rnd_timeout: got busy want idle");
      end
    end
    n_checks++;
    if (wire_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL rnd_len: got %0d want %0d",
               wire_q.size(), exp_q.size());
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        n_checks++;
        if (wire_q[j] !== exp_q[j]) begin
          n_errors++;
          $display("FAIL rnd_byte%0d: got %h want %h",
                   j, wire_q[j], exp_q[j]);
        end
      end
    end
    n_checks++;
    if (err_cyc.size() != exp_err) begin
      n_errors++;
      $display("FAIL rnd_err: got %0d pulses want %0d",
               err_cyc.size(), exp_err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    en       = '0;
    tx_en    = 1'b1;
    reset_n  = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_no_interleave();
    test_stall();
    test_overlen();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end
endmodule
